// File: rtl/div_pkg.sv
// Shared constants and state encoding for the 12-bit sequential divider.
package div_pkg;

    localparam int DIV_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_W-1:0] DBZ_QUOT = '1;

endpackage

// File: rtl/bla_sub12.sv
// Combinational borrow look-ahead subtractor: diff = a - b, bout = borrow out of the MSB.
module bla_sub12
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W-1:0] g;
    logic [W-1:0] p;

    assign g = ~a & b;
    assign p = ~(a ^ b);

    // A bit borrows if it generates one, or passes an incoming borrow through when a == b.
    always_comb begin
        logic c;
        c    = 1'b0;
        diff = '0;
        for (int i = 0; i < W; i++) begin
            diff[i] = a[i] ^ b[i] ^ c;
            c       = g[i] | (p[i] & c);
        end
        bout = c;
    end

endmodule

// File: rtl/div12_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, start/done handshake.
module div12_seq
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic [1:0]   dbg_state
);

    // Handshake: start is taken on a rising edge while IDLE or DONE; done is a
    // one-cycle pulse and results stay registered until the next done.
    div_state_e   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [W:0]   rem_q, rem_d;
    logic [W-1:0] dvd_q, dvd_d;
    logic [W-1:0] dvs_q, dvs_d;
    logic [W-1:0] quo_q, quo_d;
    logic [W-1:0] quot_q, quot_d;
    logic [W-1:0] remo_q, remo_d;
    logic         dbz_q, dbz_d;

    logic [W:0]   r_shift;
    logic [W-1:0] trial;
    logic         bout;
    logic         take;

    assign r_shift = {rem_q[W-1:0], dvd_q[W-1]};

    bla_sub12 #(.W(W)) u_sub (
        .a    (r_shift[W-1:0]),
        .b    (dvs_q),
        .diff (trial),
        .bout (bout)
    );

    // With R[W] set the shifted remainder already exceeds any W-bit divisor.
    assign take = r_shift[W] | ~bout;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                // DONE also accepts start, giving a 13-cycle back-to-back issue interval.
                if (start) begin
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = W'(DBZ_QUOT);
                        remo_d  = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        rem_d   = '0;
                        quo_d   = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = take ? {1'b0, trial} : r_shift;
                dvd_d = {dvd_q[W-2:0], 1'b0};
                quo_d = {quo_q[W-2:0], take};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(W-1)) begin
                    state_d = DONE;
                    quot_d  = quo_d;
                    remo_d  = rem_d[W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_div12_seq.sv
// Self-checking bench for div12_seq: directed cases, overlap/reset aborts and a random back-to-back sweep.
module tb_div12_seq;

    localparam int W = 12;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int n_vec = 0;
    int n_bad = 0;
    int done_cnt = 0;

    logic [2*W:0]   exp_q[$];
    logic [2*W-1:0] op_q[$];
    logic [2*W:0]   e;
    logic [2*W-1:0] o;

    div12_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // driver: called at a falling edge; start is sampled at the next rising edge (E0)
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) exp_q.push_back({1'b1, {W{1'b1}}, a});
        else         exp_q.push_back({1'b0, a / b, a % b});
        op_q.push_back({a, b});
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // returns at the falling edge where done is seen; lat counts falling edges after E0
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 1;
        busy_n = 0;
        while (!done && lat < 40) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat,
                           input logic [W-1:0] eq, input logic [W-1:0] er);
        int lat, busy_n;
        issue(a, b);
        wait_done(lat, busy_n);
        check("latency", lat, exp_lat);
        check("busy_cycles", busy_n, exp_lat - 1);
        check("quot_const", quotient, eq);
        check("rem_const", remainder, er);
    endtask

    // scoreboard: every done pops one expected result
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            check("busy_at_done", busy, 0);
            check("done_has_exp", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = op_q.pop_front();
                check("quotient", quotient, e[2*W-1:W]);
                check("remainder", remainder, e[W-1:0]);
                check("div_by_zero", div_by_zero, e[2*W]);
                if (o[W-1:0] != '0) begin
                    check("q_times_d_plus_r", 32'(quotient) * 32'(o[W-1:0]) + 32'(remainder),
                          32'(o[2*W-1:W]));
                    check("rem_lt_div", remainder < o[W-1:0], 1);
                end
            end
        end
    end

    initial begin
        int lat, busy_n, d0;
        logic [W-1:0] a, b;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quot", quotient, 0);
        check("rst_rem", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        @(negedge clk);

        run_one(12'd100, 12'd7, 13, 12'd14, 12'd2);
        repeat (3) @(negedge clk);
        check("hold_quot", quotient, 14);
        check("hold_done_low", done, 0);

        run_one(12'd4095, 12'd1, 13, 12'd4095, 12'd0);
        run_one(12'd5, 12'd9, 13, 12'd0, 12'd5);
        run_one(12'd1234, 12'd0, 1, 12'hFFF, 12'd1234);
        check("dbz_flag", div_by_zero, 1);

        // a new start clears the flag while the old quotient is still shown
        issue(12'd8, 12'd2);
        check("dbz_cleared", div_by_zero, 0);
        check("prev_quot_held", quotient, 12'hFFF);
        wait_done(lat, busy_n);
        check("latency", lat, 13);
        check("quot_8_2", quotient, 4);
        check("rem_8_2", remainder, 0);
        @(negedge clk);

        // start during RUN must be ignored
        d0 = done_cnt;
        issue(12'd300, 12'd17);
        lat = 1;
        while (!done && lat < 40) begin
            if (lat == 4) begin
                start    = 1'b1;
                dividend = 12'd50;
                divisor  = 12'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("ovl_latency", lat, 13);
        check("ovl_quot", quotient, 17);
        check("ovl_rem", remainder, 11);
        repeat (20) @(negedge clk);
        check("ovl_done_count", done_cnt - d0, 1);

        // reset mid-RUN aborts with no done
        d0 = done_cnt;
        issue(12'd2047, 12'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quot", quotient, 0);
        check("abort_rem", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        rst = 1'b0;
        exp_q.delete();
        op_q.delete();
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);

        run_one(12'd2047, 12'd3, 13, 12'd682, 12'd1);

        // random sweep issued back to back
        for (int i = 0; i < 2000; i++) begin
            a = W'($urandom_range(0, 4095));
            b = (i % 4 == 0) ? W'($urandom_range(1, 15)) : W'($urandom_range(1, 4095));
            issue(a, b);
            wait_done(lat, busy_n);
            check("rnd_latency", lat, 13);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
